// File: rtl/ahb_lite_dec_mux_if.sv
// Master-side AHB-Lite bus between the BIU and the address decoder/response mux.
interface ahb_lite_dec_mux_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] biu_pad_haddr;
  logic [1:0]        biu_pad_htrans;
  logic              biu_pad_hwrite;
  logic [2:0]        biu_pad_hsize;
  logic [2:0]        biu_pad_hburst;
  logic [3:0]        biu_pad_hprot;
  logic [DATA_W-1:0] biu_pad_hwdata;
  logic [DATA_W-1:0] pad_biu_hrdata;
  logic              pad_biu_hready;
  logic [1:0]        pad_biu_hresp;

  modport master (
    output biu_pad_haddr, biu_pad_htrans, biu_pad_hwrite, biu_pad_hsize,
           biu_pad_hburst, biu_pad_hprot, biu_pad_hwdata,
    input  pad_biu_hrdata, pad_biu_hready, pad_biu_hresp
  );

  modport slave (
    input  biu_pad_haddr, biu_pad_htrans, biu_pad_hwrite, biu_pad_hsize,
           biu_pad_hburst, biu_pad_hprot, biu_pad_hwdata,
    output pad_biu_hrdata, pad_biu_hready, pad_biu_hresp
  );
endinterface

// File: rtl/ahb_lite_dec_mux.sv
// AHB-Lite address decoder, data-phase owner tracking and response mux with an internal ERROR slave.
// Optional data-phase watchdog enabled by defining AHB_DEC_TIMEOUT_EN.
//
// state   | meaning
// DS_IDLE | default slave not responding
// DS_ERR1 | first ERROR cycle (hready 0, hresp 01)
// DS_ERR2 | second ERROR cycle (hready 1, hresp 01)
module ahb_lite_dec_mux #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}},
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      pll_core_cpuclk,
  input  logic                      pad_cpu_rst_b,
  ahb_lite_dec_mux_if.slave         bus,
  input  logic                      smpu_deny,
  output logic [NUM_SLV-1:0]        hsel_s,
  output logic                      hready_s_in,
  output logic [ADDR_W-1:0]         haddr_s,
  output logic [1:0]                htrans_s,
  output logic                      hwrite_s,
  output logic [2:0]                hsize_s,
  output logic [2:0]                hburst_s,
  output logic [3:0]                hprot_s,
  output logic [DATA_W-1:0]         hwdata_s,
  input  logic [NUM_SLV*DATA_W-1:0] hrdata_s,
  input  logic [NUM_SLV-1:0]        hready_s,
  input  logic [NUM_SLV*2-1:0]      hresp_s,
  output logic                      dec_timeout_err
);

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  ds_state_t           ds_state, ds_next;
  logic [NUM_SLV:0]    dsel;
  logic [NUM_SLV-1:0]  hit;
  logic                hit_lower;
  logic                def_sel;
  logic                active;
  logic [DATA_W-1:0]   hrdata_mux;
  logic                hready_mux;
  logic [1:0]          hresp_mux;
  logic                sel_rdy;
  logic                ext_wait;
  logic                timeout;

  assign active = bus.biu_pad_htrans[1];

  // Lowest-index hit wins on overlapping regions.
  always_comb begin
    hit       = '0;
    hsel_s    = '0;
    hit_lower = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      hit[i] = ((bus.biu_pad_haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
      hsel_s[i] = active & hit[i] & ~hit_lower & ~smpu_deny;
      hit_lower = hit_lower | hit[i];
    end
    def_sel = active & (~(|hit) | smpu_deny);
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b)
      dsel <= '0;
    else if (timeout)
      dsel <= {1'b1, {NUM_SLV{1'b0}}};
    else if (hready_mux)
      dsel <= {def_sel, hsel_s};
  end

  always_comb begin
    hrdata_mux = '0;
    hready_mux = 1'b1;
    hresp_mux  = 2'b00;
    sel_rdy    = 1'b1;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel[i]) begin
        hrdata_mux = hrdata_s[i*DATA_W +: DATA_W];
        hready_mux = hready_s[i];
        hresp_mux  = hresp_s[i*2 +: 2];
        sel_rdy    = hready_s[i];
      end
    end
    if (dsel[NUM_SLV]) begin
      hrdata_mux = '0;
      hready_mux = (ds_state != DS_ERR1);
      hresp_mux  = (ds_state == DS_IDLE) ? 2'b00 : 2'b01;
    end
    ext_wait = (|dsel[NUM_SLV-1:0]) & ~sel_rdy;
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b)
      ds_state <= DS_IDLE;
    else
      ds_state <= ds_next;
  end

  // The FSM advances on the same edge dsel captures a default transfer,
  // so its state always describes the current data-phase cycle.
  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_IDLE: if (hready_mux && def_sel) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = (hready_mux && def_sel) ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
    if (timeout)
      ds_next = DS_ERR1;
  end

`ifdef AHB_DEC_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] to_cnt;
  logic        to_pulse;

  assign timeout = ext_wait && ((to_cnt + 16'd1) == TO_LIM);

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      to_cnt   <= '0;
      to_pulse <= 1'b0;
    end else begin
      to_cnt   <= (ext_wait && !timeout) ? to_cnt + 16'd1 : 16'd0;
      to_pulse <= timeout;
    end
  end

  assign dec_timeout_err = to_pulse;
`else
  assign timeout         = 1'b0;
  assign dec_timeout_err = 1'b0;
`endif

  assign bus.pad_biu_hrdata = hrdata_mux;
  assign bus.pad_biu_hready = hready_mux;
  assign bus.pad_biu_hresp  = hresp_mux;
  assign hready_s_in        = hready_mux;
  assign haddr_s            = bus.biu_pad_haddr;
  assign htrans_s           = bus.biu_pad_htrans;
  assign hwrite_s           = bus.biu_pad_hwrite;
  assign hsize_s            = bus.biu_pad_hsize;
  assign hburst_s           = bus.biu_pad_hburst;
  assign hprot_s            = bus.biu_pad_hprot;
  assign hwdata_s           = bus.biu_pad_hwdata;

endmodule
